sat_add_arbiter: RTL and testbench



---
 rtl/sat_add_arbiter.sv | 109 ++++++++++
 tb/tb_sat_add_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sat_add_arbiter.sv
// Round-robin arbiter sharing one saturating signed adder across NUM_REQ requesters.
// Optional saturation-event counter enabled by defining SAT_ADD_ARB_STATS_EN.
module sat_add_arbiter #(
  parameter int WIDTH = 8,
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [ID_W-1:0]          res_id,
  output logic                     res_sat
`ifdef SAT_ADD_ARB_STATS_EN
  ,
  output logic [15:0]              sat_count
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] idx;
  logic [ID_W:0]   idx_wide;
  logic [NUM_REQ-1:0] grant;
  logic            found;
  logic            can_accept;
  logic            transfer;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] data_c;
  logic             sat_c;

  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  // Search from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx_wide = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_wide = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx_wide >= (ID_W+1)'(NUM_REQ))
        idx_wide = idx_wide - (ID_W+1)'(NUM_REQ);
      idx = idx_wide[ID_W-1:0];
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign res_valid  = (state == FULL);
  assign can_accept = (state == EMPTY) || res_ready;
  assign req_ready  = (can_accept && !rst) ? grant : '0;
  assign transfer   = |(req_valid & req_ready);

  assign a_sel = req_a[int'(grant_id)*WIDTH +: WIDTH];
  assign b_sel = req_b[int'(grant_id)*WIDTH +: WIDTH];
  assign sum   = {a_sel[WIDTH-1], a_sel} + {b_sel[WIDTH-1], b_sel};

  // Overflow shows as disagreement between the extra sign bit and the result sign.
  always_comb begin
    sat_c  = sum[WIDTH] ^ sum[WIDTH-1];
    data_c = sum[WIDTH-1:0];
    if (sat_c)
      data_c = sum[WIDTH] ? MIN_VAL : MAX_VAL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      ptr      <= '0;
      res_data <= '0;
      res_id   <= '0;
      res_sat  <= 1'b0;
    end else if (transfer) begin
      state    <= FULL;
      res_data <= data_c;
      res_id   <= grant_id;
      res_sat  <= sat_c;
      ptr      <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
    end else if (res_ready) begin
      state <= EMPTY;
    end
  end

`ifdef SAT_ADD_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      sat_count <= '0;
    else if (transfer && sat_c && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Self-checking bench for sat_add_arbiter: reset, saturation table, round-robin,
// backpressure, wrap-around, mid-operation reset and (with SAT_ADD_ARB_STATS_EN) the counter.
module tb_sat_add_arbiter;
  localparam int WIDTH = 8;
  localparam int NUM_REQ = 4;
  localparam int ID_W = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_data;
  logic [ID_W-1:0]          res_id;
  logic                     res_sat;
`ifdef SAT_ADD_ARB_STATS_EN
  logic [15:0]              sat_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_data;
    logic       exp_sat;
  } vec_t;

  vec_t vecs[8];

  sat_add_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
`ifdef SAT_ADD_ARB_STATS_EN
    .res_sat   (res_sat),
    .sat_count (sat_count)
`else
    .res_sat   (res_sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] valid, input int id,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic ready);
    req_valid = valid;
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
    res_ready = ready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkResult(input logic [1:0] id, input logic [7:0] data, input logic sat);
    checkOutput("res_valid", 32'(res_valid), 32'd1);
    checkOutput("res_id", 32'(res_id), 32'(id));
    checkOutput("res_data", 32'(res_data), 32'(data));
    checkOutput("res_sat", 32'(res_sat), 32'(sat));
  endtask

  initial begin
    vecs[0] = '{1, 8'h64, 8'h32, 8'h7F, 1'b1};
    vecs[1] = '{2, 8'h9C, 8'hCE, 8'h80, 1'b1};
    vecs[2] = '{3, 8'h7F, 8'h00, 8'h7F, 1'b0};
    vecs[3] = '{0, 8'hFD, 8'h05, 8'h02, 1'b0};
    vecs[4] = '{1, 8'h80, 8'hFF, 8'h80, 1'b1};
    vecs[5] = '{2, 8'h80, 8'h7F, 8'hFF, 1'b0};
    vecs[6] = '{0, 8'h7F, 8'h7F, 8'h7F, 1'b1};
    vecs[7] = '{3, 8'hC0, 8'hC0, 8'h80, 1'b0};

    // Reset held two cycles with every requester asking.
    rst = 1'b1;
    res_ready = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*8 +: 8] = 8'(i);
      req_b[i*8 +: 8] = 8'd10;
    end
    repeat (2) @(negedge clk);
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset res_data", 32'(res_data), 32'd0);
    checkOutput("reset res_id", 32'(res_id), 32'd0);
    checkOutput("reset res_sat", 32'(res_sat), 32'd0);
`ifdef SAT_ADD_ARB_STATS_EN
    checkOutput("reset sat_count", 32'(sat_count), 32'd0);
`endif

    // Round-robin with every requester valid and no backpressure.
    rst = 1'b0;
    #1 checkOutput("first grant", 32'(req_ready), 32'b0001);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkResult(2'(k % 4), 8'(k % 4 + 10), 1'b0);
    end
    req_valid = '0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'(1 << vecs[i].id), vecs[i].id, vecs[i].a, vecs[i].b, 1'b1);
      #1 checkOutput("table req_ready", 32'(req_ready), 32'(1 << vecs[i].id));
      @(negedge clk);
      checkResult(2'(vecs[i].id), vecs[i].exp_data, vecs[i].exp_sat);
      req_valid = '0;
    end

    // Backpressure: result must stay put and no grants while stalled.
    @(negedge clk);
    applyStimulus(4'b0010, 1, 8'h0A, 8'h14, 1'b0);
    #1 checkOutput("bp grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    applyStimulus(4'b0100, 2, 8'h05, 8'h06, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1 checkOutput("bp req_ready", 32'(req_ready), 32'd0);
      checkResult(2'd1, 8'h1E, 1'b0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1 checkOutput("bp release", 32'(req_ready), 32'b0100);
    @(negedge clk);
    checkResult(2'd2, 8'h0B, 1'b0);
    req_valid = '0;

    // Sparse: grant to 2 leaves ptr at 3, so 0 beats 2 through the wrap.
    applyStimulus(4'b0100, 2, 8'h01, 8'h01, 1'b1);
    #1 checkOutput("sparse grant2", 32'(req_ready), 32'b0100);
    @(negedge clk);
    checkResult(2'd2, 8'h02, 1'b0);
    applyStimulus(4'b0101, 0, 8'h20, 8'h10, 1'b1);
    #1 checkOutput("wrap grant0", 32'(req_ready), 32'b0001);
    @(negedge clk);
    checkResult(2'd0, 8'h30, 1'b0);
    req_valid = 4'b1111;
    #1 checkOutput("ptr after wrap", 32'(req_ready), 32'b0010);
    req_valid = '0;

    // Reset while holding a result discards it and returns ptr to 0.
    @(negedge clk);
    applyStimulus(4'b0010, 1, 8'h07, 8'h07, 1'b0);
    @(negedge clk);
    checkResult(2'd1, 8'h0E, 1'b0);
    req_valid = 4'b1111;
    res_ready = 1'b1;
    rst = 1'b1;
    #1 checkOutput("rst req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("midrst res_valid", 32'(res_valid), 32'd0);
    checkOutput("midrst res_data", 32'(res_data), 32'd0);
    checkOutput("midrst res_id", 32'(res_id), 32'd0);
    rst = 1'b0;
    #1 checkOutput("midrst ptr", 32'(req_ready), 32'b0001);
    req_valid = '0;

`ifdef SAT_ADD_ARB_STATS_EN
    @(negedge clk);
    checkOutput("stats cleared", 32'(sat_count), 32'd0);
    applyStimulus(4'b0001, 0, 8'h64, 8'h32, 1'b1); @(negedge clk);
    applyStimulus(4'b0001, 0, 8'h01, 8'h01, 1'b1); @(negedge clk);
    applyStimulus(4'b0001, 0, 8'h9C, 8'hCE, 1'b1); @(negedge clk);
    applyStimulus(4'b0001, 0, 8'h7F, 8'h00, 1'b1); @(negedge clk);
    applyStimulus(4'b0001, 0, 8'h7F, 8'h01, 1'b1); @(negedge clk);
    req_valid = '0;
    checkOutput("sat_count 3", 32'(sat_count), 32'd3);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*8 +: 8] = 8'h64;
      req_b[i*8 +: 8] = 8'h64;
    end
    req_valid = 4'b1111;
    repeat (65540) @(negedge clk);
    req_valid = '0;
    checkOutput("sat_count sticky", 32'(sat_count), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
